if_id_buffer: RTL and testbench
===============================

# if_id_buffer

- Decoupling buffer between the instruction fetch stage and the decode stage.
- Accepts {PC, instruction} pairs from fetch through a valid/ready handshake and holds them in a small FIFO.
- Presents the oldest entry to decode together with its pre-split register fields and sign-extended immediate.
- Flushes all held entries on a control-flow redirect.

## Interface
Parameters:
- DEPTH, 2, number of entries; power of two, ≥2
- XLEN, 64, PC and immediate width

Ports:
- Clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- if_valid  in  1  fetch offers an entry
- if_pc  in  XLEN  PC of offered instruction
- if_instr  in  32  offered instruction word
- if_ready  out  1  buffer can accept an entry this cycle
- flush  in  1  redirect; discard all entries
- id_ready  in  1  decode consumes head entry this cycle
- id_valid  out  1  head entry present
- id_pc  out  XLEN  head PC
- id_instr  out  32  head instruction
- id_opcode  out  7  head instr[6:0]
- id_rd  out  5  head instr[11:7]
- id_funct3  out  3  head instr[14:12]
- id_rs1  out  5  head instr[19:15]
- id_rs2  out  5  head instr[24:20]
- id_funct7  out  7  head instr[31:25]
- id_imm  out  XLEN  sign-extended immediate of head
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Push: if_valid && if_ready at a rising edge writes {if_pc, if_instr} at the write pointer.
- Pop: id_valid && id_ready at a rising edge advances the read pointer.
- Pointers wrap modulo DEPTH.
- Same-edge push and pop:
  - count unchanged; both pointers advance.
  - When empty, the pop is not possible (id_valid=0), so count becomes 1.
- if_ready = (count < DEPTH) && reset high. There is no combinational path from id_ready, so a full buffer refuses a push even while a pop happens that cycle.
- id_valid = (count != 0).
- Head outputs are show-ahead (read combinationally from the storage at the read pointer).
- When empty:
  - id_instr = 32'h00000013 (NOP).
  - id_pc = 0.
  - Field outputs and id_imm are those of the NOP.
- Flush (synchronous):
  - At the edge where flush=1, count←0 and both pointers←0.
  - A simultaneous push or pop is discarded.
  - flush has priority over everything except reset.
- Immediate selection by opcode, always sign-extended from instr[31]:
  - I-type (0000011, 0010011, 1100111): instr[31:20].
  - S-type (0100011): {instr[31:25], instr[11:7]}.
  - B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}.
  - J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - Any other opcode: 0.

## Timing
- Reset low, asynchronous:
  - count=0, pointers=0, id_valid=0, if_ready=0.
  - id_instr=32'h00000013, id_pc=0, statistics counters=0.
- Storage array is not reset.
- After reset rises, if_ready=1 in the same cycle.
- Latency: an entry pushed at edge N is visible on id_* after edge N (cycle N+1).
- With id_ready held high, throughput is one entry per cycle.
- Full (count=DEPTH): if_ready=0; the held if_* must stay stable under fetch's own stall.
- Reset asserted mid-transfer aborts everything; no entry survives.

## Configuration
- IF_ID_STATS_EN defined: adds two outputs, each a 32-bit wrapping counter cleared by reset.
  - stall_cycles (32): increments every cycle with if_valid && !if_ready.
  - flushed_entries (32): adds count at each edge where flush=1.
- IF_ID_STATS_EN undefined: these ports and their logic are absent.

## Test plan
- Reset then single entry:
  - Stimulus: push pc=0x0, instr=0x003100B3 (ADD x1,x2,x3).
  - Response next cycle: id_valid=1, id_rd=1, id_rs1=2, id_rs2=3, id_funct7=0, id_imm=0.
- Load immediate:
  - Stimulus: push 0x01053383 (LD x7,16(x10)).
  - Response: id_opcode=7'b0000011, id_funct3=3, id_imm=16.
- Negative branch:
  - Stimulus: push 0xFE000EE3 (BEQ x0,x0,-4).
  - Response: id_imm=64'hFFFF_FFFF_FFFF_FFFC.
- Fill and wrap:
  - With id_ready=0, push DEPTH entries; then if_ready=0 and count=DEPTH.
  - Then id_ready=1 with continuous pushes for 3×DEPTH cycles; PCs emerge in order with none lost or duplicated.
- Flush:
  - With count=2 and simultaneous push and pop, assert flush.
  - Next cycle: count=0, id_valid=0, id_instr=0x00000013; with IF_ID_STATS_EN, flushed_entries=2.
- Async reset mid-stream:
  - Drop reset between clock edges while count=1.
  - Outputs reach reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/if_id_buffer.sv
// IF/ID decoupling FIFO: show-ahead head with pre-split fields and sign-extended immediate.
// Optional statistics counters are enabled by defining IF_ID_STATS_EN.
module if_id_buffer #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 64
) (
    input  logic                       Clk,
    input  logic                       reset,
    input  logic                       if_valid,
    input  logic [XLEN-1:0]            if_pc,
    input  logic [31:0]                if_instr,
    output logic                       if_ready,
    input  logic                       flush,
    input  logic                       id_ready,
    output logic                       id_valid,
    output logic [XLEN-1:0]            id_pc,
    output logic [31:0]                id_instr,
    output logic [6:0]                 id_opcode,
    output logic [4:0]                 id_rd,
    output logic [2:0]                 id_funct3,
    output logic [4:0]                 id_rs1,
    output logic [4:0]                 id_rs2,
    output logic [6:0]                 id_funct7,
    output logic [XLEN-1:0]            id_imm,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef IF_ID_STATS_EN
    ,
    output logic [31:0]                stall_cycles,
    output logic [31:0]                flushed_entries
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [XLEN-1:0]  pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    function automatic logic signed [XLEN-1:0] imm_gen(input logic [31:0] instr);
        logic signed [31:0] imm32;
        imm32 = '0;
        case (instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111:
                imm32 = {{20{instr[31]}}, instr[31:20]};
            7'b0100011:
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            7'b1100011:
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm32 = {instr[31:12], 12'b0};
            7'b1101111:
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
        return XLEN'(imm32);
    endfunction

    // Readiness depends only on occupancy, never on id_ready, so a full buffer stalls fetch.
    assign if_ready = (count < CNT_W'(DEPTH)) && reset;
    assign id_valid = (count != '0);
    assign push     = if_valid && if_ready;
    assign pop      = id_valid && id_ready;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage holds data only and is deliberately left unreset.
    always_ff @(posedge Clk) begin
        if (push && !flush) begin
            pc_mem[wr_ptr]    <= if_pc;
            instr_mem[wr_ptr] <= if_instr;
        end
    end

    assign id_instr  = id_valid ? instr_mem[rd_ptr] : NOP;
    assign id_pc     = id_valid ? pc_mem[rd_ptr] : '0;
    assign id_opcode = id_instr[6:0];
    assign id_rd     = id_instr[11:7];
    assign id_funct3 = id_instr[14:12];
    assign id_rs1    = id_instr[19:15];
    assign id_rs2    = id_instr[24:20];
    assign id_funct7 = id_instr[31:25];
    assign id_imm    = imm_gen(id_instr);

`ifdef IF_ID_STATS_EN
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            stall_cycles    <= '0;
            flushed_entries <= '0;
        end else begin
            if (if_valid && !if_ready)
                stall_cycles <= stall_cycles + 32'd1;
            if (flush)
                flushed_entries <= flushed_entries + 32'(count);
        end
    end
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Randomised scoreboard bench for if_id_buffer with a queue-based reference model.
// Statistics checks are compiled in when IF_ID_STATS_EN is defined.
module tb_if_id_buffer;

    localparam int DEPTH = 4;
    localparam int XLEN  = 64;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic             Clk = 1'b0;
    logic             reset;
    logic             if_valid;
    logic [XLEN-1:0]  if_pc;
    logic [31:0]      if_instr;
    logic             if_ready;
    logic             flush;
    logic             id_ready;
    logic             id_valid;
    logic [XLEN-1:0]  id_pc;
    logic [31:0]      id_instr;
    logic [6:0]       id_opcode;
    logic [4:0]       id_rd;
    logic [2:0]       id_funct3;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [6:0]       id_funct7;
    logic [XLEN-1:0]  id_imm;
    logic [CNT_W-1:0] count;
`ifdef IF_ID_STATS_EN
    logic [31:0]      stall_cycles;
    logic [31:0]      flushed_entries;
    logic [31:0]      m_stall = 0;
    logic [31:0]      m_flushed = 0;
`endif

    ent_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    if_id_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .Clk(Clk), .reset(reset),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
        .flush(flush), .id_ready(id_ready), .id_valid(id_valid),
        .id_pc(id_pc), .id_instr(id_instr), .id_opcode(id_opcode), .id_rd(id_rd),
        .id_funct3(id_funct3), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_funct7(id_funct7),
        .id_imm(id_imm), .count(count)
`ifdef IF_ID_STATS_EN
        , .stall_cycles(stall_cycles), .flushed_entries(flushed_entries)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [63:0] ref_imm(input logic [31:0] i);
        longint s;
        s = longint'($signed(i));
        case (i[6:0])
            7'h03, 7'h13, 7'h67: return s >>> 20;
            7'h23: return ((s >>> 25) <<< 5) | longint'(i[11:7]);
            7'h63: return ((s >>> 31) <<< 12) | (longint'(i[7]) <<< 11)
                          | (longint'(i[30:25]) <<< 5) | (longint'(i[11:8]) <<< 1);
            7'h37, 7'h17: return (s >>> 12) <<< 12;
            7'h6F: return ((s >>> 31) <<< 20) | (longint'(i[19:12]) <<< 12)
                          | (longint'(i[20]) <<< 11) | (longint'(i[30:21]) <<< 1);
            default: return 64'd0;
        endcase
    endfunction

    // Called at posedge+1; the queue then holds exactly the entries the buffer should hold.
    task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                         input logic rdy, input logic fl);
        logic acc;
        if_valid = v; if_pc = pc; if_instr = ins; id_ready = rdy; flush = fl;
        acc = v && !fl && reset && (exp_q.size() < DEPTH);
`ifdef IF_ID_STATS_EN
        if (fl) m_flushed = m_flushed + 32'(exp_q.size());
`endif
        @(posedge Clk); #1;
        if (fl) exp_q.delete();
        else if (acc) exp_q.push_back('{pc, ins});
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63,
                                  7'h37, 7'h17, 7'h6F, 7'h33, 7'h73};
        logic [31:0] r;
        r = $urandom;
        return {r[31:7], ops[$urandom_range(0, 9)]};
    endfunction

    // Monitor: compare the presented head against the scoreboard, retire on handshake.
    always @(negedge Clk) begin
        ent_t e;
        chk("count", 64'(count), 64'(exp_q.size()));
        chk("id_valid", 64'(id_valid), 64'(exp_q.size() != 0));
        chk("if_ready", 64'(if_ready), 64'(reset && (exp_q.size() < DEPTH)));
`ifdef IF_ID_STATS_EN
        chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
        chk("flushed_entries", 64'(flushed_entries), 64'(m_flushed));
        if (reset && if_valid && exp_q.size() >= DEPTH) m_stall = m_stall + 1;
`endif
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            chk("id_pc", id_pc, e.pc);
            chk("id_instr", 64'(id_instr), 64'(e.ins));
            chk("id_opcode", 64'(id_opcode), 64'(e.ins[6:0]));
            chk("id_rd", 64'(id_rd), 64'(e.ins[11:7]));
            chk("id_funct3", 64'(id_funct3), 64'(e.ins[14:12]));
            chk("id_rs1", 64'(id_rs1), 64'(e.ins[19:15]));
            chk("id_rs2", 64'(id_rs2), 64'(e.ins[24:20]));
            chk("id_funct7", 64'(id_funct7), 64'(e.ins[31:25]));
            chk("id_imm", id_imm, ref_imm(e.ins));
            if (id_ready && !flush) void'(exp_q.pop_front());
        end else begin
            chk("empty_instr", 64'(id_instr), 64'(NOP));
            chk("empty_pc", id_pc, 64'd0);
            chk("empty_imm", id_imm, 64'd0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] pc;
        reset = 1'b0; if_valid = 1'b0; if_pc = '0; if_instr = '0; flush = 1'b0; id_ready = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_if_ready", 64'(if_ready), 64'd0);
        chk("rst_id_instr", 64'(id_instr), 64'(NOP));
        reset = 1'b1;
        #1;
        chk("rel_if_ready", 64'(if_ready), 64'd1);
        @(posedge Clk); #1;

        // Directed decode cases.
        drive(1, 64'h0, 32'h003100B3, 0, 0);
        chk("add_valid", 64'(id_valid), 64'd1);
        chk("add_rd", 64'(id_rd), 64'd1);
        chk("add_rs1", 64'(id_rs1), 64'd2);
        chk("add_rs2", 64'(id_rs2), 64'd3);
        chk("add_funct7", 64'(id_funct7), 64'd0);
        chk("add_imm", id_imm, 64'd0);
        drive(0, 64'h0, 32'h0, 1, 0);
        drive(1, 64'h4, 32'h01053383, 0, 0);
        chk("ld_opcode", 64'(id_opcode), 64'h03);
        chk("ld_funct3", 64'(id_funct3), 64'd3);
        chk("ld_imm", id_imm, 64'd16);
        drive(0, 64'h0, 32'h0, 1, 0);
        drive(1, 64'h8, 32'hFE000EE3, 0, 0);
        chk("beq_imm", id_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        drive(0, 64'h0, 32'h0, 1, 0);

        // Fill, then stream with wrap-around.
        pc = 64'h1000;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, pc, rand_instr(), 0, 0);
            pc += 4;
        end
        chk("full_if_ready", 64'(if_ready), 64'd0);
        chk("full_count", 64'(count), 64'(DEPTH));
        for (int i = 0; i < 3 * DEPTH; i++) begin
            drive(1, pc, rand_instr(), 1, 0);
            pc += 4;
        end
        for (int i = 0; i <= DEPTH; i++) drive(0, 64'h0, 32'h0, 1, 0);
        chk("drained_count", 64'(count), 64'd0);

        // Flush with simultaneous push and pop.
        drive(1, 64'h2000, rand_instr(), 0, 0);
        drive(1, 64'h2004, rand_instr(), 0, 0);
        drive(1, 64'h2008, rand_instr(), 1, 1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(id_valid), 64'd0);
        chk("flush_instr", 64'(id_instr), 64'(NOP));
`ifdef IF_ID_STATS_EN
        chk("flush_stats", 64'(flushed_entries), 64'd2);
`endif

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, pc, rand_instr(), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 31) == 0);
            pc += 4;
        end
        for (int i = 0; i <= DEPTH; i++) drive(0, 64'h0, 32'h0, 1, 0);

        // Asynchronous reset between edges with one entry held.
        drive(1, 64'h3000, rand_instr(), 0, 0);
        chk("pre_rst_count", 64'(count), 64'd1);
        if_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_valid", 64'(id_valid), 64'd0);
        chk("arst_if_ready", 64'(if_ready), 64'd0);
        chk("arst_instr", 64'(id_instr), 64'(NOP));
        chk("arst_pc", id_pc, 64'd0);
`ifdef IF_ID_STATS_EN
        m_stall = 0; m_flushed = 0;
        chk("arst_stall", 64'(stall_cycles), 64'd0);
        chk("arst_flushed", 64'(flushed_entries), 64'd0);
`endif
        @(posedge Clk); #1;
        reset = 1'b1;
        #1;
        chk("post_rst_if_ready", 64'(if_ready), 64'd1);
        @(posedge Clk); #1;
        drive(0, 64'h0, 32'h0, 1, 0);
        drive(0, 64'h0, 32'h0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
